// File: rtl/aurva_axi_mem_responder_if.sv
// AXI4 (subset) bus between a kernel m_axi master and the memory responder.
// Only the fields the responder uses are carried; responses are always OKAY.
interface aurva_axi_mem_responder_if #(
  parameter int unsigned C_ADDR_WIDTH = 64,
  parameter int unsigned C_DATA_WIDTH = 256
);
  logic                      s_axi_awvalid;
  logic                      s_axi_awready;
  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic [7:0]                s_axi_awlen;
  logic                      s_axi_wvalid;
  logic                      s_axi_wready;
  logic [C_DATA_WIDTH-1:0]   s_axi_wdata;
  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                      s_axi_wlast;
  logic                      s_axi_bvalid;
  logic                      s_axi_bready;
  logic                      s_axi_arvalid;
  logic                      s_axi_arready;
  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr;
  logic [7:0]                s_axi_arlen;
  logic                      s_axi_rvalid;
  logic                      s_axi_rready;
  logic [C_DATA_WIDTH-1:0]   s_axi_rdata;
  logic                      s_axi_rlast;

  modport master (
    output s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
    output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
    output s_axi_bready,
    output s_axi_arvalid, s_axi_araddr, s_axi_arlen,
    output s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bvalid,
    input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rlast
  );

  modport slave (
    input  s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
    input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
    input  s_axi_bready,
    input  s_axi_arvalid, s_axi_araddr, s_axi_arlen,
    input  s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bvalid,
    output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rlast
  );
endinterface

// File: rtl/aurva_axi_mem_responder.sv
// BRAM-backed AXI4 slave memory: independent INCR-burst read and write FSMs,
// one outstanding burst per direction, read-first on same-word collisions.
module aurva_axi_mem_responder #(
  parameter int unsigned             C_ADDR_WIDTH = 64,
  parameter int unsigned             C_DATA_WIDTH = 256,
  parameter int unsigned             C_MEM_DEPTH  = 1024,
  parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR  = '0
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  aurva_axi_mem_responder_if.slave        axi,
  output logic                            proto_err
);
  localparam int unsigned BytesPerWord = C_DATA_WIDTH / 8;
  localparam int unsigned IdxLsb       = $clog2(BytesPerWord);
  localparam int unsigned IdxW         = $clog2(C_MEM_DEPTH);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;

  logic [C_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

  // Word index comes from the offset above the base; the upper bits wrap away.
  logic [C_ADDR_WIDTH-1:0] aw_off, ar_off;
  logic                    aw_unaligned, ar_unaligned;
  logic                    unused_off_hi;
  assign aw_off        = axi.s_axi_awaddr - C_BASE_ADDR;
  assign ar_off        = axi.s_axi_araddr - C_BASE_ADDR;
  assign aw_unaligned  = |aw_off[IdxLsb-1:0];
  assign ar_unaligned  = |ar_off[IdxLsb-1:0];
  assign unused_off_hi = ^{aw_off[C_ADDR_WIDTH-1:IdxLsb+IdxW], ar_off[C_ADDR_WIDTH-1:IdxLsb+IdxW]};

  // ---------------- write channel ----------------
  logic [1:0]      wstate_q, wstate_d;
  logic            awready_q;
  logic [IdxW-1:0] widx_q;
  logic [7:0]      wcnt_q, wlen_q;
  logic            aw_hs, w_hs, w_cnt_end, w_end;

  assign aw_hs     = axi.s_axi_awvalid && awready_q;
  assign w_hs      = axi.s_axi_wvalid && (wstate_q == W_DATA);
  assign w_cnt_end = (wcnt_q == wlen_q);
  assign w_end     = w_hs && (axi.s_axi_wlast || w_cnt_end);

  always_comb begin
    wstate_d = wstate_q;
    unique case (wstate_q)
      W_IDLE:  if (aw_hs) wstate_d = W_DATA;
      W_DATA:  if (w_end) wstate_d = W_RESP;
      W_RESP:  if (axi.s_axi_bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // Ready is registered so it stays low for the first cycle after reset.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      widx_q    <= '0;
      wcnt_q    <= '0;
      wlen_q    <= '0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= (wstate_d == W_IDLE);
      if (aw_hs) begin
        widx_q <= aw_off[IdxLsb +: IdxW];
        wcnt_q <= '0;
        wlen_q <= axi.s_axi_awlen;
      end
      if (w_hs) begin
        widx_q <= widx_q + IdxW'(1);
        wcnt_q <= wcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (w_hs && !areset) begin
      for (int b = 0; b < BytesPerWord; b++) begin
        if (axi.s_axi_wstrb[b]) mem[widx_q][8*b +: 8] <= axi.s_axi_wdata[8*b +: 8];
      end
    end
  end

  assign axi.s_axi_awready = awready_q;
  assign axi.s_axi_wready  = (wstate_q == W_DATA);
  assign axi.s_axi_bvalid  = (wstate_q == W_RESP);

  // ---------------- read channel ----------------
  logic [1:0]              rstate_q, rstate_d;
  logic                    arready_q;
  logic [IdxW-1:0]         ridx_q;
  logic [7:0]              rcnt_q, rlen_q;
  logic [C_DATA_WIDTH-1:0] rdata_q;
  logic                    ar_hs, r_hs, rvalid, rlast, rd_en;

  assign rvalid = (rstate_q == R_DATA);
  assign rlast  = rvalid && (rcnt_q == rlen_q);
  assign ar_hs  = axi.s_axi_arvalid && arready_q;
  assign r_hs   = rvalid && axi.s_axi_rready;
  // Prefetch the next word on every accepted non-final beat for back-to-back beats.
  assign rd_en  = (rstate_q == R_FETCH) || (r_hs && !rlast);

  always_comb begin
    rstate_d = rstate_q;
    unique case (rstate_q)
      R_IDLE:  if (ar_hs) rstate_d = R_FETCH;
      R_FETCH: rstate_d = R_DATA;
      R_DATA:  if (r_hs && rlast) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      ridx_q    <= '0;
      rcnt_q    <= '0;
      rlen_q    <= '0;
      rdata_q   <= '0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= (rstate_d == R_IDLE);
      if (ar_hs) begin
        ridx_q <= ar_off[IdxLsb +: IdxW];
        rcnt_q <= '0;
        rlen_q <= axi.s_axi_arlen;
      end
      if (rd_en) begin
        rdata_q <= mem[ridx_q];
        ridx_q  <= ridx_q + IdxW'(1);
      end
      if (r_hs) rcnt_q <= rcnt_q + 8'd1;
    end
  end

  assign axi.s_axi_arready = arready_q;
  assign axi.s_axi_rvalid  = rvalid;
  assign axi.s_axi_rdata   = rdata_q;
  assign axi.s_axi_rlast   = rlast;

  // ---------------- protocol error flag ----------------
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      proto_err <= 1'b0;
    end else if ((aw_hs && aw_unaligned) || (ar_hs && ar_unaligned) ||
                 (w_hs && (axi.s_axi_wlast != w_cnt_end))) begin
      proto_err <= 1'b1;
    end
  end
endmodule
